iter_shifter: RTL and testbench
===============================

# iter_shifter

Multi-cycle, parametrised successor to the single-cycle combinational shifter in the ALU datapath. It accepts one shift request through a valid/ready handshake and resolves the shift amount a fixed number of bits per cycle. It returns the result through a second valid/ready handshake. It serves multi-cycle execution paths where a full-width barrel shifter would be too large or too slow.

## Interface
- DATA_WIDTH, 32, operand/result width; power of two, ≥ 4
- BITS_PER_CYCLE, 1, shift-amount bits resolved per SHIFT cycle; must divide SHAMT_W
- (derived) SHAMT_W = log2(DATA_WIDTH); N_ITER = SHAMT_W / BITS_PER_CYCLE
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request
- in_A  in  DATA_WIDTH  operand
- in_B  in  SHAMT_W  shift amount
- in_op  in  2  00 SLL, 01 ROR, 10 SRL, 11 SRA
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- out_result  out  DATA_WIDTH  shifted value

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: capture in_A into the working register, and capture in_B and in_op; clear the iteration counter k; go to SHIFT.
- SHIFT:
  - Each cycle, take chunk c = B[k*BITS_PER_CYCLE +: BITS_PER_CYCLE].
  - Apply an op-specific shift of the working register by c << (k*BITS_PER_CYCLE); then k++.
  - After iteration k = N_ITER−1, go to DONE.
- Op-specific shift rules:
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: fill with the MSB of the working register, i.e. the original sign.
  - ROR: rotate right, with bits leaving the LSB entering at the MSB.
- DONE:
  - out_valid = 1 and out_result = working register.
  - On out_ready: go to IDLE; out_valid drops on the next cycle.
- Every op takes exactly N_ITER SHIFT cycles regardless of the B value; B = 0 returns A unchanged.
- Shift amounts are taken modulo DATA_WIDTH; the SHAMT_W width enforces this.
- in_ready = (state == IDLE) && !rst. Inputs are not accepted in SHIFT or DONE, so at most one request is in flight.
- in_A/in_B/in_op are sampled only on the accept edge; later changes are ignored.

## Timing
- Reset values: state IDLE, out_valid 0, out_result 0, working register 0, k 0; in_ready 0 while rst is high.
- Latency: a request accepted at edge t gives out_valid high from edge t+N_ITER. With default parameters, N_ITER = 5, so the result is visible in the cycle after the 5th SHIFT edge.
- Minimum request-to-request spacing: N_ITER+2 cycles, assuming out_ready is held high.
- Back-pressure: while out_valid && !out_ready, out_result and out_valid stay stable and in_ready stays 0.
- rst asserted in any state returns the block to IDLE on that edge and discards the in-flight request; no out_valid is produced for it.
- rst and in_valid high in the same cycle: the request is not accepted.

## Configuration
- SHIFTER_ROTATE_EN defined: in_op 01 performs rotate-right as above.
- SHIFTER_ROTATE_EN undefined:
  - in_op 01 is still accepted, with identical latency and handshake.
  - out_result = 0 for that request.
  - No rotate wrap logic is built.

## Test plan
- SLL, default parameters: A=0x0000_0001, B=31, op=00 → out_result 0x8000_0000, out_valid exactly 5 edges after accept.
- SRA: A=0x8000_00F0, B=4, op=11 → 0xF800_000F; same A with op=10 → 0x0800_000F.
- ROR with SHIFTER_ROTATE_EN: A=0x1234_5678, B=8, op=01 → 0x7812_3456. Without the macro, the same stimulus → 0x0000_0000 with the same latency.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid. Result and out_valid remain stable, in_ready stays 0, and a new in_valid is ignored until the result is consumed.
- Reset mid-operation: assert rst for 1 cycle at the 2nd SHIFT cycle. Block returns to IDLE, out_valid never rises for that request, and the next request A=0xFFFF_FFFF, B=0, op=10 returns 0xFFFF_FFFF.
- DATA_WIDTH=64, BITS_PER_CYCLE=2: A=0x1, B=63, op=00 → 0x8000_0000_0000_0000 after 3 SHIFT cycles.

Source files
------------

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shifter that resolves BITS_PER_CYCLE bits of the
// shift amount per cycle (SLL, ROR, SRL, SRA) behind valid/ready handshakes
// on the request and result sides.
// Optional feature macro: SHIFTER_ROTATE_EN. When it is defined, op 01 rotates
// right. When it is undefined, op 01 keeps the same handshake and latency but
// returns zero, and no rotate logic is built.
module iter_shifter #(
   parameter int DATA_WIDTH     = 32,
   parameter int BITS_PER_CYCLE = 1,
   localparam int SHAMT_W       = $clog2(DATA_WIDTH),
   localparam int N_ITER        = SHAMT_W / BITS_PER_CYCLE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_A,
   input  logic [SHAMT_W-1:0]    in_B,
   input  logic [1:0]            in_op,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_result
);

   localparam int K_W = (N_ITER > 1) ? $clog2(N_ITER) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(N_ITER - 1);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b10;
   localparam logic [1:0] OP_SRA = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t                  state_reg, state_next;
   logic [DATA_WIDTH-1:0]   work_reg, work_next;
   logic [K_W-1:0]          k_reg, k_next;
   logic [SHAMT_W-1:0]      b_reg, b_next;
   logic [1:0]              op_reg, op_next;

   // Per-iteration shift distance: chunk k of B, already weighted by its position.
   logic [SHAMT_W-1:0]      amt_table [N_ITER];
   logic [SHAMT_W-1:0]      amt;
   logic [DATA_WIDTH-1:0]   shifted;

   genvar gi;
   generate
      for (gi = 0; gi < N_ITER; gi++) begin : g_amt
         assign amt_table[gi] =
            SHAMT_W'(b_reg[gi*BITS_PER_CYCLE +: BITS_PER_CYCLE]) << (gi*BITS_PER_CYCLE);
      end
   endgenerate

   // Select the distance for the current iteration with a one-hot style match on k.
   always_comb begin
      amt = '0;
      for (int i = 0; i < N_ITER; i++) begin
         if (k_reg == K_W'(i)) begin
            amt = amt_table[i];
         end
      end
   end

`ifdef SHIFTER_ROTATE_EN
   // Left distance for the wrap-around half of a rotate; (-amt) mod DATA_WIDTH
   // also makes a zero distance collapse to the unshifted word.
   logic [SHAMT_W-1:0]      neg_amt;
   assign neg_amt = (~amt) + SHAMT_W'(1);
`endif

   // One step of the requested operation on the working register.
   always_comb begin
      shifted = work_reg;
      case (op_reg)
         OP_SLL:  shifted = work_reg << amt;
         OP_SRL:  shifted = work_reg >> amt;
         OP_SRA:  shifted = $unsigned($signed(work_reg) >>> amt);
         default: begin
`ifdef SHIFTER_ROTATE_EN
            shifted = (work_reg >> amt) | (work_reg << neg_amt);
`else
            // Rotate is not built: the request still runs its full length
            // but the result is forced to zero.
            shifted = '0;
`endif
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         work_reg  <= '0;
         k_reg     <= '0;
         b_reg     <= '0;
         op_reg    <= '0;
      end else begin
         state_reg <= state_next;
         work_reg  <= work_next;
         k_reg     <= k_next;
         b_reg     <= b_next;
         op_reg    <= op_next;
      end
   end

   // Next-state logic: accept in IDLE, iterate N_ITER times, hold result until taken.
   always_comb begin
      state_next = state_reg;
      work_next  = work_reg;
      k_next     = k_reg;
      b_next     = b_reg;
      op_next    = op_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               work_next  = in_A;
               b_next     = in_B;
               op_next    = in_op;
               k_next     = '0;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            work_next = shifted;
            if (k_reg == K_LAST) begin
               k_next     = '0;
               state_next = DONE;
            end else begin
               k_next = k_reg + K_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign in_ready   = (state_reg == IDLE) && !rst;
   assign out_valid  = (state_reg == DONE);
   assign out_result = out_valid ? work_reg : '0;

endmodule

// File: tb/tb_iter_shifter.sv
// Testbench for iter_shifter: a 32-bit/1-bit-per-cycle instance and a
// 64-bit/2-bits-per-cycle instance, checked against table vectors, an
// arithmetic reference model on random requests, and hand sequences for
// back-pressure and reset.
module tb_iter_shifter;

   logic clk = 1'b0;
   logic rst;

   logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready;
   logic [31:0] n_in_A, n_out_result;
   logic [4:0]  n_in_B;
   logic [1:0]  n_in_op;

   logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
   logic [63:0] w_in_A, w_out_result;
   logic [5:0]  w_in_B;
   logic [1:0]  w_in_op;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   iter_shifter #(.DATA_WIDTH(32), .BITS_PER_CYCLE(1)) dut_n (
      .clk(clk), .rst(rst),
      .in_valid(n_in_valid), .in_ready(n_in_ready),
      .in_A(n_in_A), .in_B(n_in_B), .in_op(n_in_op),
      .out_valid(n_out_valid), .out_ready(n_out_ready), .out_result(n_out_result)
   );

   iter_shifter #(.DATA_WIDTH(64), .BITS_PER_CYCLE(2)) dut_w (
      .clk(clk), .rst(rst),
      .in_valid(w_in_valid), .in_ready(w_in_ready),
      .in_A(w_in_A), .in_B(w_in_B), .in_op(w_in_op),
      .out_valid(w_out_valid), .out_ready(w_out_ready), .out_result(w_out_result)
   );

   typedef struct {
      logic [31:0] a;
      int          b;
      logic [1:0]  op;
      logic [31:0] exp;
   } vec_t;

   // Whole-word reference: a w-bit shift done in one step on 64-bit integers.
   function automatic logic [63:0] model(input logic [63:0] a_in, input int sh,
                                         input logic [1:0] op, input int w);
      logic [63:0] mask;
      logic [63:0] a;
      logic [63:0] r;
      mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      a = a_in & mask;
      r = '0;
      case (op)
         2'b00: r = (a << sh) & mask;
         2'b10: r = a >> sh;
         2'b11: begin
            r = a >> sh;
            if (a[w-1]) r = r | (mask & ~(mask >> sh));
         end
         default: begin
`ifdef SHIFTER_ROTATE_EN
            r = ((a >> sh) | (a << (w - sh))) & mask;
`else
            r = '0;
`endif
         end
      endcase
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issue one request to the chosen instance (called at a negedge with it idle),
   // wait for the result with out_ready held high, then confirm out_valid drops.
   task automatic run_req(input bit wide, input logic [63:0] a, input int b,
                          input logic [1:0] op, output logic [63:0] res, output int lat);
      bit got;
      if (wide) begin
         w_in_A = a; w_in_B = 6'(b); w_in_op = op; w_in_valid = 1'b1;
         check("accept_ready", {63'd0, w_in_ready}, 64'd1);
      end else begin
         n_in_A = a[31:0]; n_in_B = 5'(b); n_in_op = op; n_in_valid = 1'b1;
         check("accept_ready", {63'd0, n_in_ready}, 64'd1);
      end
      @(posedge clk);
      #1;
      // Scramble the inputs after the accept edge; they must be ignored.
      w_in_valid = 1'b0; n_in_valid = 1'b0;
      w_in_A = {$urandom, $urandom}; w_in_B = 6'($urandom); w_in_op = 2'($urandom);
      n_in_A = $urandom; n_in_B = 5'($urandom); n_in_op = 2'($urandom);
      lat = 0;
      res = '0;
      got = 1'b0;
      while (!got && lat <= 40) begin
         @(negedge clk);
         if (wide ? w_out_valid : n_out_valid) begin
            got = 1'b1;
            res = wide ? w_out_result : {32'd0, n_out_result};
         end else begin
            @(posedge clk);
            lat++;
         end
      end
      if (!got) begin
         tests++;
         fails++;
         $display("FAIL timeout: no out_valid within %0d cycles, required one", lat);
      end
      $display("[TB] %s A=%h B=%0d op=%0d -> %h after %0d cycles",
               wide ? "w64" : "w32", a, b, op, res, lat);
      @(posedge clk);
      @(negedge clk);
      check("valid_drop", {63'd0, wide ? w_out_valid : n_out_valid}, 64'd0);
   endtask

   initial begin
      vec_t        vecs[8];
      logic [63:0] res;
      logic [63:0] exp;
      int          lat;
      int          b;
      logic [1:0]  op;
      logic [63:0] a;
      bit          saw_valid;

      vecs[0] = '{32'h0000_0001, 31, 2'b00, 32'h8000_0000};
      vecs[1] = '{32'h8000_00F0, 4,  2'b11, 32'hF800_000F};
      vecs[2] = '{32'h8000_00F0, 4,  2'b10, 32'h0800_000F};
`ifdef SHIFTER_ROTATE_EN
      vecs[3] = '{32'h1234_5678, 8,  2'b01, 32'h7812_3456};
      vecs[4] = '{32'hCAFE_F00D, 0,  2'b01, 32'hCAFE_F00D};
`else
      vecs[3] = '{32'h1234_5678, 8,  2'b01, 32'h0000_0000};
      vecs[4] = '{32'hCAFE_F00D, 0,  2'b01, 32'h0000_0000};
`endif
      vecs[5] = '{32'hDEAD_BEEF, 0,  2'b00, 32'hDEAD_BEEF};
      vecs[6] = '{32'h7000_0000, 31, 2'b11, 32'h0000_0000};
      vecs[7] = '{32'hFFFF_FFFF, 31, 2'b11, 32'hFFFF_FFFF};

      rst = 1'b1;
      n_in_valid = 1'b0; n_in_A = '0; n_in_B = '0; n_in_op = '0; n_out_ready = 1'b1;
      w_in_valid = 1'b0; w_in_A = '0; w_in_B = '0; w_in_op = '0; w_out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_out_valid", {63'd0, n_out_valid}, 64'd0);
      check("rst_out_result", {32'd0, n_out_result}, 64'd0);
      check("rst_in_ready", {63'd0, n_in_ready}, 64'd0);
      check("rst_w_out_valid", {63'd0, w_out_valid}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", {63'd0, n_in_ready}, 64'd1);

      // Table vectors on the 32-bit instance.
      for (int i = 0; i < 8; i++) begin
         run_req(1'b0, {32'd0, vecs[i].a}, vecs[i].b, vecs[i].op, res, lat);
         check($sformatf("vec%0d_result", i), res, {32'd0, vecs[i].exp});
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'd5);
      end

      // Random requests against the reference model, 32-bit.
      for (int i = 0; i < 30; i++) begin
         a = {32'd0, $urandom};
         b = int'($urandom_range(0, 31));
         op = 2'($urandom_range(0, 3));
         exp = model(a, b, op, 32);
         run_req(1'b0, a, b, op, res, lat);
         check("rand32_result", res, exp);
         check("rand32_latency", 64'(lat), 64'd5);
      end

      // 64-bit instance, 2 bits per cycle: directed then random.
      run_req(1'b1, 64'd1, 63, 2'b00, res, lat);
      check("w64_sll63", res, 64'h8000_0000_0000_0000);
      check("w64_latency", 64'(lat), 64'd3);
      for (int i = 0; i < 12; i++) begin
         a = {$urandom, $urandom};
         b = int'($urandom_range(0, 63));
         op = 2'($urandom_range(0, 3));
         exp = model(a, b, op, 64);
         run_req(1'b1, a, b, op, res, lat);
         check("rand64_result", res, exp);
         check("rand64_latency", 64'(lat), 64'd3);
      end

      // Back-pressure: result held for 10 cycles, new requests ignored meanwhile.
      n_out_ready = 1'b0;
      n_in_A = 32'hA5A5_0000; n_in_B = 5'd3; n_in_op = 2'b10; n_in_valid = 1'b1;
      @(posedge clk);
      #1;
      n_in_valid = 1'b0;
      saw_valid = 1'b0;
      for (int i = 0; i < 40 && !saw_valid; i++) begin
         @(negedge clk);
         saw_valid = n_out_valid;
      end
      check("bp_valid_seen", {63'd0, saw_valid}, 64'd1);
      for (int i = 0; i < 10; i++) begin
         check("bp_valid_hold", {63'd0, n_out_valid}, 64'd1);
         check("bp_result_hold", {32'd0, n_out_result}, 64'h0000_0000_14B4_A000);
         check("bp_in_ready", {63'd0, n_in_ready}, 64'd0);
         n_in_A = $urandom; n_in_B = 5'($urandom); n_in_op = 2'b00; n_in_valid = 1'b1;
         @(negedge clk);
      end
      n_in_valid = 1'b0;
      n_out_ready = 1'b1;
      @(negedge clk);
      check("bp_consumed", {63'd0, n_out_valid}, 64'd0);
      check("bp_ready_back", {63'd0, n_in_ready}, 64'd1);
      saw_valid = 1'b0;
      repeat (8) begin
         @(negedge clk);
         saw_valid = saw_valid | n_out_valid;
      end
      check("bp_no_stray_result", {63'd0, saw_valid}, 64'd0);

      // Reset during the second SHIFT cycle discards the request.
      n_in_A = 32'h0F0F_0F0F; n_in_B = 5'd1; n_in_op = 2'b00; n_in_valid = 1'b1;
      @(posedge clk);
      #1;
      n_in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_in_ready", {63'd0, n_in_ready}, 64'd0);
      check("midrst_out_valid", {63'd0, n_out_valid}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_idle", {63'd0, n_in_ready}, 64'd1);
      saw_valid = 1'b0;
      repeat (15) begin
         @(negedge clk);
         saw_valid = saw_valid | n_out_valid;
      end
      check("midrst_no_result", {63'd0, saw_valid}, 64'd0);
      run_req(1'b0, 64'h0000_0000_FFFF_FFFF, 0, 2'b10, res, lat);
      check("postrst_result", res, 64'h0000_0000_FFFF_FFFF);
      check("postrst_latency", 64'(lat), 64'd5);

      // rst and in_valid together: the request must not be taken.
      rst = 1'b1;
      n_in_A = 32'h1234_0000; n_in_B = 5'd2; n_in_op = 2'b00; n_in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("rst_valid_ready", {63'd0, n_in_ready}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      n_in_valid = 1'b0;
      saw_valid = 1'b0;
      repeat (10) begin
         @(negedge clk);
         saw_valid = saw_valid | n_out_valid;
      end
      check("rst_valid_not_taken", {63'd0, saw_valid}, 64'd0);
      check("rst_valid_idle", {63'd0, n_in_ready}, 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
